// File: rtl/gate_delay_pipe_if.sv
// Bundle of the gate_delay_pipe data ports: operands, counter clear, the gate
// outputs and the hazard observation signals.
interface gate_delay_pipe_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cnt_clr;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] E;
    logic             hazard;
    logic [CNT_W-1:0] hazard_cnt;

    modport master (
        output A,
        output B,
        output cnt_clr,
        input  D,
        input  E,
        input  hazard,
        input  hazard_cnt
    );

    modport slave (
        input  A,
        input  B,
        input  cnt_clr,
        output D,
        output E,
        output hazard,
        output hazard_cnt
    );
endinterface

// File: rtl/gate_delay_pipe.sv
// Clocked AND -> NOT -> OR hazard structure: each gate delay is a flop chain,
// replicated per bit-channel, with a static-1 hazard detector and onset counter.
module gate_delay_pipe #(
    parameter int WIDTH   = 4,
    parameter int AND_LAT = 3,
    parameter int NOT_LAT = 2,
    parameter int OR_LAT  = 1,
    parameter int CNT_W   = 8
) (
    input logic               clk,
    input logic               rst_n,
    gate_delay_pipe_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZEROS    = {WIDTH{1'b0}};

    logic [WIDTH-1:0] and_r [AND_LAT];
    logic [WIDTH-1:0] not_r [NOT_LAT];
    logic [WIDTH-1:0] or_r  [OR_LAT];

    logic [WIDTH-1:0] w1_s;
    logic [WIDTH-1:0] e_s;
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] d_next_s;
    logic             onset_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    function automatic logic all_ones(input logic [WIDTH-1:0] v);
        return &v;
    endfunction

    assign w1_s = and_r[AND_LAT-1];
    assign e_s  = not_r[NOT_LAT-1];
    assign d_s  = or_r[OR_LAT-1];

    // AND gate delay line; reset mirrors A=B=0 applied forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AND_LAT; i++) begin
                and_r[i] <= ZEROS;
            end
        end else begin
            and_r[0] <= bus.A & bus.B;
            for (int i = 1; i < AND_LAT; i++) begin
                and_r[i] <= and_r[i-1];
            end
        end
    end

    // NOT gate delay line; its output idles high because w1 idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOT_LAT; i++) begin
                not_r[i] <= ONES;
            end
        end else begin
            not_r[0] <= ~w1_s;
            for (int i = 1; i < NOT_LAT; i++) begin
                not_r[i] <= not_r[i-1];
            end
        end
    end

    // OR gate delay line; both OR inputs are sampled in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OR_LAT; i++) begin
                or_r[i] <= ONES;
            end
        end else begin
            or_r[0] <= w1_s | e_s;
            for (int i = 1; i < OR_LAT; i++) begin
                or_r[i] <= or_r[i-1];
            end
        end
    end

    // The value D will take at the coming edge, so an onset is counted on the
    // same edge that D leaves all-ones.
    generate
        if (OR_LAT == 1) begin : g_dnext_direct
            assign d_next_s = w1_s | e_s;
        end else begin : g_dnext_chain
            assign d_next_s = or_r[OR_LAT-2];
        end
    endgenerate

    // Onset detection and saturating count; clear overrides a coincident onset.
    always_comb begin
        onset_s    = all_ones(d_s) & ~all_ones(d_next_s);
        cnt_next_s = cnt_r;
        if (bus.cnt_clr) begin
            cnt_next_s = CNT_ZERO;
        end else if (onset_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Hazard counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign bus.D          = d_s;
    assign bus.E          = e_s;
    assign bus.hazard     = ~all_ones(d_s);
    assign bus.hazard_cnt = cnt_r;

endmodule

// File: tb/tb_gate_delay_pipe.sv
// Directed bench for gate_delay_pipe: default-parameter instance for timing and
// independence, plus a CNT_W=2 instance for saturation and clear.
module tb_gate_delay_pipe;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    gate_delay_pipe_if #(.WIDTH(4), .CNT_W(8)) if_main ();
    gate_delay_pipe_if #(.WIDTH(4), .CNT_W(2)) if_sat ();

    gate_delay_pipe #(.WIDTH(4), .AND_LAT(3), .NOT_LAT(2), .OR_LAT(1), .CNT_W(8)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_main.slave)
    );

    gate_delay_pipe #(.WIDTH(4), .AND_LAT(3), .NOT_LAT(2), .OR_LAT(1), .CNT_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_sat.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // A/B sampled at edge 10, zero sampled at edge 30; stops after edge stop_at.
    task automatic run_pattern(input logic [3:0] a, input logic [3:0] b,
                               input int stop_at, input int base_cnt);
        logic [3:0] and_v;
        logic [3:0] exp_d;
        logic [3:0] exp_e;
        int         exp_cnt;
        and_v = a & b;
        for (int c = 1; c <= stop_at; c++) begin
            if (c == 10) begin
                if_main.A = a;
                if_main.B = b;
            end
            if (c == 30) begin
                if_main.A = 4'h0;
                if_main.B = 4'h0;
            end
            tick();
            exp_e   = (c >= 14 && c < 34) ? ~and_v : 4'hF;
            exp_d   = (c == 33 || c == 34) ? ~and_v : 4'hF;
            exp_cnt = base_cnt + ((c >= 33 && and_v != 4'h0) ? 1 : 0);
            if (c >= 9) begin
                chk("E", 32'(if_main.E), 32'(exp_e));
                chk("D", 32'(if_main.D), 32'(exp_d));
                chk("hazard", 32'(if_main.hazard), (exp_d != 4'hF) ? 32'd1 : 32'd0);
                chk("hazard_cnt", 32'(if_main.hazard_cnt), 32'(exp_cnt));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b1;
        if_main.A = 4'h0; if_main.B = 4'h0; if_main.cnt_clr = 1'b0;
        if_sat.A  = 4'h0; if_sat.B  = 4'h0; if_sat.cnt_clr  = 1'b0;

        // 1: reset acts before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_E", 32'(if_main.E), 32'h0000_000F);
        chk("rst_D", 32'(if_main.D), 32'h0000_000F);
        chk("rst_hazard", 32'(if_main.hazard), 32'd0);
        chk("rst_cnt", 32'(if_main.hazard_cnt), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        repeat (4) tick();
        chk("hold_E", 32'(if_main.E), 32'h0000_000F);
        chk("hold_D", 32'(if_main.D), 32'h0000_000F);
        chk("hold_hazard", 32'(if_main.hazard), 32'd0);
        chk("hold_cnt", 32'(if_main.hazard_cnt), 32'd0);

        // 2+3: full-width rise then fall
        rst_n = 1'b0;
        #1;
        release_reset();
        run_pattern(4'hF, 4'hF, 40, 0);

        // 6: reset in the middle of the glitch
        rst_n = 1'b0;
        #1;
        release_reset();
        run_pattern(4'hF, 4'hF, 33, 0);
        chk("pre_rst_D", 32'(if_main.D), 32'h0000_0000);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_D", 32'(if_main.D), 32'h0000_000F);
        chk("midrst_hazard", 32'(if_main.hazard), 32'd0);
        chk("midrst_cnt", 32'(if_main.hazard_cnt), 32'd0);
        if_main.A = 4'h0;
        if_main.B = 4'h0;
        release_reset();
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("post_rst_D", 32'(if_main.D), 32'h0000_000F);
            chk("post_rst_cnt", 32'(if_main.hazard_cnt), 32'd0);
        end

        // 4: only channel 0 sees A&B=1
        rst_n = 1'b0;
        #1;
        release_reset();
        run_pattern(4'b0011, 4'b0001, 40, 0);

        // 5: saturation at 3 and clear winning over a coincident onset
        for (int i = 0; i < 6; i++) begin
            if_sat.A = 4'h1;
            if_sat.B = 4'h1;
            repeat (6) tick();
            if_sat.A = 4'h0;
            if_sat.B = 4'h0;
            repeat (3) tick();
            if (i == 5) begin
                chk("sat_before_clr", 32'(if_sat.hazard_cnt), 32'd3);
                if_sat.cnt_clr = 1'b1;
            end
            tick();
            if_sat.cnt_clr = 1'b0;
            chk("sat_hazard", 32'(if_sat.hazard), 32'd1);
            chk("sat_cnt", 32'(if_sat.hazard_cnt), (i == 5) ? 32'd0 : ((i >= 2) ? 32'd3 : 32'(i + 1)));
            repeat (4) tick();
            chk("sat_D_back", 32'(if_sat.D), 32'h0000_000F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_delay_pipe.md
Name: gate_delay_pipe

Overview:
- Clocked, parametrised successor to the team's two-input gate-delay teaching circuit (AND → NOT → OR hazard structure).
- Each gate's propagation delay becomes a configurable number of register stages. Physical gate delays become cycle-exact, synthesisable latencies.
- The block is replicated across WIDTH independent bit-channels.
- It adds a static-1 hazard detector and a saturating hazard event counter, so the D-output glitch can be observed and measured in simulation and in silicon.

Parameters:
- WIDTH, 4, number of independent bit-channels (≥1)
- AND_LAT, 3, register stages of the AND gate (≥1)
- NOT_LAT, 2, register stages of the NOT gate (≥1)
- OR_LAT, 1, register stages of the OR gate (≥1)
- CNT_W, 8, hazard counter width (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A, per channel
- B  input  WIDTH  operand B, per channel
- cnt_clr  input  1  synchronous clear of hazard_cnt
- D  output  WIDTH  OR output: w1 | E, per channel
- E  output  WIDTH  NOT output: ~w1, per channel
- hazard  output  1  high while any bit of D is 0
- hazard_cnt  output  CNT_W  saturating count of hazard onsets

Behaviour:
- Interface decisions: one clock, clk. Reset is rst_n, asynchronous and active-low. The C input of the earlier circuit has no function and is omitted.
- Stage convention: a stage of latency L is a chain of L flops. An input sampled at edge k is visible at the stage output after edge k+L−1.
- Datapath, per channel:
  - w1 = AND_LAT-delayed (A & B).
  - E = NOT_LAT-delayed ~w1.
  - D = OR_LAT-delayed (w1 | E). Both OR inputs are taken from the same cycle, then delayed together.
- Latency for an A/B change sampled at edge k:
  - w1 changes after edge k+AND_LAT−1.
  - E changes after edge k+AND_LAT+NOT_LAT−1.
  - D sees the w1 change after edge k+AND_LAT+OR_LAT−1.
  - D sees the E change after edge k+AND_LAT+NOT_LAT+OR_LAT−1.
- Hazard:
  - When w1 falls 1→0, D is 0 for exactly NOT_LAT cycles, because E has not yet risen.
  - When w1 rises, D stays 1, because E falls NOT_LAT cycles after w1 rose.
  - hazard = ~&D (combinational from the D flops).
- hazard_cnt:
  - Increments at any edge where the D flops go from all-ones to not-all-ones. This is a hazard onset.
  - Onsets are counted once per onset, not once per channel and not once per cycle.
  - The count saturates at 2^CNT_W−1.
- cnt_clr:
  - Clears hazard_cnt to 0 at the next edge.
  - If cnt_clr and an onset occur on the same edge, the clear wins and the result is 0.
- Reset: every internal flop behaves as if A=B=0 had been applied forever.
  - w1 chain = 0.
  - E chain = all ones.
  - D chain = all ones.
  - Outputs E = {WIDTH{1}}, D = {WIDTH{1}}, hazard = 0, hazard_cnt = 0.
  - Reset takes effect immediately on rst_n falling, with no clock required.
  - Reset mid-glitch aborts the glitch: D returns to all ones, and no onset is counted on release.
- Channels are fully independent. Glitches on several channels in overlapping cycles count as one onset while D stays not-all-ones.
- There are no X-propagation guarantees for X inputs. Outputs are defined only for known A/B.

Test Plan:
1. Defaults, reset, A=B=0:
   - E=4'hF, D=4'hF, hazard=0 and hazard_cnt=0 immediately on reset assertion, no clock edges required.
   - Values hold after release.
2. Defaults, A=B=4'hF sampled at edge 10:
   - E=4'h0 after edge 14.
   - D stays 4'hF throughout.
   - hazard never asserts; hazard_cnt=0.
3. Continuing, A=B=0 sampled at edge 30:
   - D=4'h0 after edges 33 and 34, back to 4'hF after edge 35.
   - E=4'hF after edge 34.
   - hazard high for exactly 2 cycles.
   - hazard_cnt=1 after edge 33.
4. Per-channel independence:
   - A=4'b0011, B=4'b0001 sampled at edge 10, then A=B=0 at edge 30.
   - Only D[0] glitches, giving D=4'b1110 for 2 cycles.
   - E bits 3:1 remain 1 throughout.
   - hazard_cnt increments by 1.
5. Saturation and clear, CNT_W=2:
   - Five falling-w1 events → hazard_cnt reads 1, 2, 3, 3, 3.
   - cnt_clr asserted on the same edge as the 6th onset → hazard_cnt=0.
6. Reset mid-glitch:
   - rst_n low after edge 33 of scenario 3 → D=4'hF and hazard=0 immediately, hazard_cnt=0.
   - After release with A=B=0, no further onset; hazard_cnt stays 0.
